pulse_handshake_src: RTL and testbench

- Source-domain end of a four-phase req/ack pulse transfer. Turns single-cycle pulses on sig_a into one full req_a/ack_b handshake each, toward a receiver in another clock domain.
- Pulses that arrive while a handshake is in flight are counted and replayed, so bursts are not lost up to counter depth.
- Sits in the fast or source domain, next to the toggle/edge-detect receivers already used for CDC pulses.

---
 rtl/pulse_handshake_src.sv | 101 ++++++++++
 tb/tb_pulse_handshake_src.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_handshake_src.sv
// Source-domain end of a four-phase req/ack pulse transfer with a pending-pulse counter.
// Optional handshake timeout: define PULSE_HANDSHAKE_SRC_TIMEOUT_EN.
module pulse_handshake_src #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TO_W        = 8
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             sig_a,
  input  logic             ack_b,
  output logic             req_a,
  output logic             busy,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             drop,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TO_W < 1) begin : g_bad_to
    $error("TO_W must be at least 1");
  end

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       pend_q, pend_d;
  logic                   req_q, drop_q;
  logic                   ack_s, launch, accept, full, timeout;

  always_comb begin
    ack_s  = sync_q[SYNC_STAGES-1];
    full   = (pend_q == PEND_MAX);
    launch = (state_q == IDLE) && (sig_a || (pend_q != '0));
    // A launch frees a slot in the same cycle, so a pulse on a full counter survives it.
    accept = sig_a && (!full || launch);

    pend_d = pend_q;
    if (accept && !launch)      pend_d = pend_q + 1'b1;
    else if (!accept && launch) pend_d = pend_q - 1'b1;

    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = REQ;
      REQ:     if (ack_s)  state_d = REL;
      REL:     if (!ack_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      pend_q  <= '0;
      req_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ack_b};
      pend_q  <= pend_d;
      req_q   <= (state_d == REQ);
      drop_q  <= sig_a && !accept;
    end
  end

`ifdef PULSE_HANDSHAKE_SRC_TIMEOUT_EN
  logic [TO_W-1:0] to_q;
  logic            err_q;

  assign timeout = (state_q != IDLE) && (to_q == '1);

  always_ff @(posedge clka) begin
    if (rst) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_d != state_q)  to_q <= '0;
      else if (state_q != IDLE) to_q <= to_q + 1'b1;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign req_a    = req_q;
  assign busy     = (state_q != IDLE) || (pend_q != '0);
  assign pend_cnt = pend_q;
  assign drop     = drop_q;

endmodule

// File: tb/tb_pulse_handshake_src.sv
// Directed bench for pulse_handshake_src: vector table plus multi-cycle handshake sequences.
module tb_pulse_handshake_src;

  logic       clka = 1'b0;
  logic       rst, sig_a, ack_b;
  logic       req_a, busy, drop, err;
  logic [3:0] pend_cnt;

  logic       rx_en, man_ack, rx_ack;
  logic [1:0] rx_dly;
  logic       req_prev;
  int         rises, drops;
  int         n_cmp, n_fail;

  pulse_handshake_src #(.CNT_W(4), .SYNC_STAGES(2), .TO_W(4)) dut (
    .clka(clka), .rst(rst), .sig_a(sig_a), .ack_b(ack_b),
    .req_a(req_a), .busy(busy), .pend_cnt(pend_cnt), .drop(drop), .err(err)
  );

  always #5 clka = ~clka;

  // Receiver model: ack follows req about three cycles later.
  always @(posedge clka) begin
    rx_dly <= {rx_dly[0], req_a};
    rx_ack <= rx_dly[1];
  end
  assign ack_b = rx_en ? rx_ack : man_ack;

  initial begin
    req_prev = 1'b0; rises = 0; drops = 0;
    rx_dly = 2'b00; rx_ack = 1'b0;
  end
  always @(posedge clka) begin
    req_prev <= req_a;
    if (req_a && !req_prev) rises <= rises + 1;
    if (drop) drops <= drops + 1;
  end

  typedef struct {
    logic       rst, sig, ack;
    logic       req, busy;
    logic [3:0] pend;
    logic       drop;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      step();
      n++;
    end
    chk({name, "_idle_timeout"}, 0, busy, 1'b0);
    repeat (8) step();
  endtask

  initial begin
    int r0, d0, peak;
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; sig_a = 1'b0; man_ack = 1'b0; rx_en = 1'b0;

    //              rst   sig   ack   req   busy  pend   drop
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0};

    @(negedge clka);
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; sig_a = tbl[i].sig; man_ack = tbl[i].ack;
      step();
      chk("req_a", i, req_a, tbl[i].req);
      chk("busy", i, busy, tbl[i].busy);
      chk("pend_cnt", i, pend_cnt, tbl[i].pend);
      chk("drop", i, drop, tbl[i].drop);
      chk("err", i, err, 1'b0);
    end

    // Single pulse with the receiver model: pulse at cycle 5 after reset.
    rst = 1'b1; sig_a = 1'b0; man_ack = 1'b0; rx_en = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    r0 = rises; d0 = drops;
    sig_a = 1'b1;
    step();
    sig_a = 1'b0;
    chk("single_req_next_cycle", 0, req_a, 1'b1);
    wait_idle(100, "single");
    chk("single_rises", 0, rises - r0, 1);
    chk("single_pend", 0, pend_cnt, 0);
    chk("single_drops", 0, drops - d0, 0);
    chk("single_req_low", 0, req_a, 1'b0);

    // Burst of five consecutive pulses.
    r0 = rises; d0 = drops; peak = 0;
    for (int i = 0; i < 5; i++) begin
      sig_a = 1'b1;
      step();
      if (pend_cnt > peak) peak = pend_cnt;
    end
    sig_a = 1'b0;
    for (int i = 0; i < 200 && busy; i++) begin
      step();
      if (pend_cnt > peak) peak = pend_cnt;
    end
    chk("burst_peak", 0, peak, 4);
    wait_idle(50, "burst");
    chk("burst_rises", 0, rises - r0, 5);
    chk("burst_pend", 0, pend_cnt, 0);
    chk("burst_drops", 0, drops - d0, 0);

`ifndef PULSE_HANDSHAKE_SRC_TIMEOUT_EN
    // Overflow: ack stuck low, twenty pulses back to back.
    rx_en = 1'b0; man_ack = 1'b0;
    r0 = rises; d0 = drops;
    for (int i = 0; i < 20; i++) begin
      sig_a = 1'b1;
      step();
      if (i == 16) chk("ovf_drop_pulse17", i, drop, 1'b1);
      if (i == 15) chk("ovf_no_drop_pulse16", i, drop, 1'b0);
    end
    sig_a = 1'b0;
    step();
    chk("ovf_pend_sat", 0, pend_cnt, 15);
    chk("ovf_drops", 0, drops - d0, 4);
    chk("ovf_req_held", 0, req_a, 1'b1);
    rx_en = 1'b1;
    wait_idle(800, "ovf");
    chk("ovf_handshakes", 0, rises - r0, 16);
    chk("ovf_pend_end", 0, pend_cnt, 0);
`endif

`ifdef PULSE_HANDSHAKE_SRC_TIMEOUT_EN
    // Timeout: ack held low after a single pulse.
    rx_en = 1'b0; man_ack = 1'b0;
    sig_a = 1'b1;
    step();
    sig_a = 1'b0;
    chk("to_req_rise", 0, req_a, 1'b1);
    repeat (15) step();
    chk("to_req_before", 0, req_a, 1'b1);
    chk("to_err_before", 0, err, 1'b0);
    step();
    chk("to_req_after", 0, req_a, 1'b0);
    chk("to_err_after", 0, err, 1'b1);
    rx_en = 1'b1;
    repeat (4) step();
    r0 = rises;
    sig_a = 1'b1;
    step();
    sig_a = 1'b0;
    wait_idle(100, "to_resume");
    chk("to_resume_rises", 0, rises - r0, 1);
    chk("to_err_sticky", 0, err, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("to_err_cleared", 0, err, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
